// File: rtl/fetch.sv
// Instruction fetch stage: PC, single-outstanding imem read, {pc, inst} push into the instruction queue.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt of cycles spent blocked in HOLD by a full queue.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        enqueue,
  output logic [63:0] enqueue_wdata,
  input  logic        is_full,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;

  // The response strobe and queue status act in the same cycle, so the handshake outputs are decoded from state.
  always_comb begin
    imem_addr     = {pc[31:2], 2'b00};
    imem_rmask    = 4'h0;
    enqueue       = 1'b0;
    enqueue_wdata = 64'd0;
    if (!rst) begin
      case (state)
        S_REQ: begin
          if (!redirect_valid) imem_rmask = 4'hf;
        end
        S_WAIT: begin
          if (imem_resp) begin
            enqueue_wdata = {pc, imem_rdata};
            enqueue       = !is_full && !redirect_valid;
          end
        end
        S_HOLD: begin
          enqueue_wdata = {pc, hold_buf};
          enqueue       = !is_full && !redirect_valid;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= S_REQ;
      hold_buf <= 32'd0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      hold_buf <= 32'd0;
      case (state)
        S_REQ:   state <= S_REQ;
        S_WAIT:  state <= imem_resp ? S_REQ : S_DISCARD;
        S_HOLD:  state <= S_REQ;
        // A response landing now retires the stale read; waiting on would deadlock.
        default: state <= imem_resp ? S_REQ : S_DISCARD;
      endcase
    end else begin
      case (state)
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (imem_resp) begin
            if (is_full) begin
              hold_buf <= imem_rdata;
              state    <= S_HOLD;
            end else begin
              pc    <= pc + 32'd4;
              state <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!is_full) begin
            pc       <= pc + 32'd4;
            hold_buf <= 32'd0;
            state    <= S_REQ;
          end
        end
        default: begin
          if (imem_resp) state <= S_REQ;
        end
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (state == S_HOLD && is_full && !redirect_valid && stall_cnt != 32'hffffffff) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios then random traffic, checked against a transaction-level model.
module tb_fetch;

  localparam logic [31:0] RPC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        enqueue;
  logic [63:0] enqueue_wdata;
  logic        is_full;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .enqueue(enqueue), .enqueue_wdata(enqueue_wdata),
    .is_full(is_full),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: next program-order PC, one read in flight, at most one fetched-but-unqueued word.
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_addr;
  int          m_cnt;
  bit          m_pend;
  int          lat = 1;
  bit          rand_lat = 0;
  int          enq_total = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h5a5a0f0f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit full, input bit redir, input logic [31:0] rpc, input bit do_rst);
    bit fresh, exp_enq, exp_req;
    rst            = do_rst;
    is_full        = full;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_resp      = 1'b0;
    imem_rdata     = $urandom;
    if (!do_rst && m_out && m_cnt == 1) begin
      imem_resp  = 1'b1;
      imem_rdata = mem_word(m_addr);
    end
    #1;
    if (do_rst) begin
      chk("rst_enqueue", {63'd0, enqueue}, 64'd0);
      chk("rst_rmask", {60'd0, imem_rmask}, 64'd0);
      chk("rst_wdata", enqueue_wdata, 64'd0);
      m_pc = RPC; m_out = 0; m_stale = 0; m_pend = 0; m_cnt = 0;
    end else begin
      fresh   = imem_resp && !m_stale;
      exp_enq = !redir && !full && (m_pend || fresh);
      exp_req = !redir && !m_out && !m_pend;
      chk("enqueue", {63'd0, enqueue}, {63'd0, exp_enq});
      chk("rmask", {60'd0, imem_rmask}, exp_req ? 64'hf : 64'h0);
      if (exp_enq) begin
        chk("wdata", enqueue_wdata, {m_pc, mem_word(m_pc)});
        enq_total++;
      end
      if (exp_req) chk("addr", {32'd0, imem_addr}, {32'd0, m_pc});
      if (m_out) m_cnt--;
      if (imem_resp) m_out = 0;
      if (redir) begin
        m_pc = rpc; m_pend = 0;
        if (m_out) m_stale = 1;
      end else if (exp_enq) begin
        m_pc = m_pc + 32'd4; m_pend = 0;
      end else if (fresh) begin
        m_pend = 1;
      end
      if (exp_req) begin
        m_out = 1; m_stale = 0; m_addr = m_pc;
        m_cnt = rand_lat ? $urandom_range(1, 3) : lat;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; is_full = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_resp = 1'b0; imem_rdata = 32'd0;

    // Back-to-back fetch, 1-cycle memory, queue never full.
    repeat (3) step(0, 0, 0, 1);
    lat = 1;
    repeat (10) step(0, 0, 0, 0);

    // Queue full when the first word returns, held for five cycles.
    repeat (2) step(0, 0, 0, 1);
    repeat (6) step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);

    // Redirect while waiting on a 3-cycle read.
    lat = 3;
    repeat (2) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 32'h1eceb100, 0);
    repeat (12) step(0, 0, 0, 0);

    // Redirect coincident with the response.
    lat = 1;
    repeat (2) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 32'h1eceb200, 0);
    repeat (6) step(0, 0, 0, 0);

    // Redirect while a word sits in the hold buffer.
    repeat (2) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 32'h1eceb300, 0);
    repeat (6) step(0, 0, 0, 0);

    // PC wraps from the top of the address space.
    step(0, 1, 32'hfffffffc, 0);
    repeat (10) step(0, 0, 0, 0);

    // Random traffic: variable latency, queue pressure, redirects, occasional reset.
    rand_lat = 1;
    enq_total = 0;
    for (int i = 0; i < 3000; i++) begin
      bit f, r, z;
      f = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 5);
      z = ($urandom_range(0, 999) < 5);
      step(f, r, {$urandom_range(0, 32'h3fffffff), 2'b00}, z);
    end
    chk("progress", {63'd0, enq_total > 100}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
